// File: rtl/cla_pkg.sv
// Shared defaults, pipeline-depth helper and per-stage control record for the pipelined CLA adder.
package cla_pkg;

  localparam int unsigned CLA_WIDTH_DEF = 16;
  localparam int unsigned CLA_GROUP_DEF = 4;

  // Per-stage control word; data fields vary in width per stage and live in the top.
  typedef struct packed {
    logic valid;
    logic carry;
  } cla_ctl_t;

  // Number of pipeline stages; a zero GROUP is rejected elsewhere, so avoid dividing by it here.
  function automatic int unsigned cla_depth(input int unsigned width, input int unsigned group);
    return (group == 0) ? 32'd1 : width / group;
  endfunction

endpackage

// File: rtl/cla_pipe_adder_if.sv
// Operand/result stream bundle for cla_pipe_adder; the ovf signal exists only when CLA_OVF_EN is defined.
interface cla_pipe_adder_if #(
  parameter int unsigned WIDTH = cla_pkg::CLA_WIDTH_DEF
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] ain;
  logic [WIDTH-1:0] bin;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
`ifdef CLA_OVF_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, ain, bin, cin, out_ready,
    input  in_ready, out_valid, s,
`ifdef CLA_OVF_EN
    input  ovf,
`endif
    input  cout
  );

  modport slave (
    input  in_valid, ain, bin, cin, out_ready,
    output in_ready, out_valid, s,
`ifdef CLA_OVF_EN
    output ovf,
`endif
    output cout
  );

endinterface

// File: rtl/cla_group.sv
// Combinational GROUP-bit carry-lookahead slice. With CLA_OVF_EN defined it also
// exports the carry into its top bit for signed-overflow detection.
module cla_group #(
  parameter int unsigned GROUP = 4
) (
  input  logic [GROUP-1:0] a_i,
  input  logic [GROUP-1:0] b_i,
  input  logic             ci_i,
  output logic [GROUP-1:0] sum_o,
`ifdef CLA_OVF_EN
  output logic             c_msb_o,
`endif
  output logic             co_o
);

  logic [GROUP-1:0] g;
  logic [GROUP-1:0] p;
  logic [GROUP:0]   c;
  logic             run;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  // Each carry is its own sum of G/P products; no carry feeds the next one.
  always_comb begin
    c    = '0;
    run  = 1'b1;
    c[0] = ci_i;
    for (int i = 1; i <= int'(GROUP); i++) begin
      run = 1'b1;
      for (int j = i - 1; j >= 0; j--) begin
        c[i] = c[i] | (run & g[j]);
        run  = run & p[j];
      end
      c[i] = c[i] | (run & ci_i);
    end
  end

  assign sum_o = p ^ c[GROUP-1:0];
  assign co_o  = c[GROUP];
`ifdef CLA_OVF_EN
  assign c_msb_o = c[GROUP-1];
`endif

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder: one GROUP-bit slice per stage, global-stall valid/ready stream.
// Define CLA_OVF_EN to add the registered signed-overflow output.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = CLA_WIDTH_DEF,
  parameter int unsigned GROUP = CLA_GROUP_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  cla_pipe_adder_if.slave bus
);

  localparam int unsigned L = cla_depth(WIDTH, GROUP);

  if ((GROUP < 1) || (WIDTH < GROUP) || ((WIDTH % ((GROUP < 1) ? 1 : GROUP)) != 0)) begin : g_bad_cfg
    $error("cla_pipe_adder: WIDTH must be a positive multiple of GROUP (GROUP >= 1)");
  end

  logic adv_c;

  assign adv_c       = bus.out_ready | ~bus.out_valid;
  assign bus.in_ready = adv_c;

  // Stage k resolves bits [k*GROUP +: GROUP]; operands above are carried right-aligned,
  // finished sum bits below are carried along until the last stage.
  for (genvar k = 0; k < L; k++) begin : g_stg
    localparam int unsigned LO = (k + 1) * GROUP;
    localparam int unsigned HI = WIDTH - LO;

    logic [HI+GROUP-1:0] a_in;
    logic [HI+GROUP-1:0] b_in;
    logic                c_in;
    logic                v_in;
    logic [GROUP-1:0]    s_sl;
    logic                co_sl;
    logic [LO-1:0]       s_d;
    logic [LO-1:0]       s_q;
    cla_ctl_t            ctl_q;
`ifdef CLA_OVF_EN
    logic                cm_sl;
`endif

    if (k == 0) begin : g_src
      assign a_in = bus.ain;
      assign b_in = bus.bin;
      assign c_in = bus.cin;
      assign v_in = bus.in_valid;
      assign s_d  = s_sl;
    end else begin : g_src
      assign a_in = g_stg[k-1].g_skew.a_q;
      assign b_in = g_stg[k-1].g_skew.b_q;
      assign c_in = g_stg[k-1].ctl_q.carry;
      assign v_in = g_stg[k-1].ctl_q.valid;
      assign s_d  = {s_sl, g_stg[k-1].s_q};
    end

    cla_group #(.GROUP(GROUP)) u_grp (
      .a_i     (a_in[GROUP-1:0]),
      .b_i     (b_in[GROUP-1:0]),
      .ci_i    (c_in),
      .sum_o   (s_sl),
`ifdef CLA_OVF_EN
      .c_msb_o (cm_sl),
`endif
      .co_o    (co_sl)
    );

    // Data only moves for real operations so an idle pipe keeps its last result.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ctl_q <= '0;
        s_q   <= '0;
      end else if (adv_c) begin
        ctl_q.valid <= v_in;
        if (v_in) begin
          ctl_q.carry <= co_sl;
          s_q         <= s_d;
        end
      end
    end

    if (HI > 0) begin : g_skew
      logic [HI-1:0] a_q;
      logic [HI-1:0] b_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv_c && v_in) begin
          a_q <= a_in[HI+GROUP-1:GROUP];
          b_q <= b_in[HI+GROUP-1:GROUP];
        end
      end
    end

`ifdef CLA_OVF_EN
    if (k == L - 1) begin : g_ovf
      logic ovf_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (adv_c && v_in) begin
          ovf_q <= cm_sl ^ co_sl;
        end
      end
    end else begin : g_tie
      logic unused_cm;
      assign unused_cm = cm_sl;
    end
`endif
  end

  assign bus.out_valid = g_stg[L-1].ctl_q.valid;
  assign bus.cout      = g_stg[L-1].ctl_q.carry;
  assign bus.s         = g_stg[L-1].s_q;
`ifdef CLA_OVF_EN
  assign bus.ovf       = g_stg[L-1].g_ovf.ovf_q;
`endif

endmodule
